// File: rtl/prime_pkg.sv
// Shared types and defaults for the prime range scanner.
// Holds the FSM state encoding and the default widths.
package prime_pkg;

    localparam int W_DEF          = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TEST,
        PUSH,
        NEXT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/prime_fifo.sv
// Small synchronous FIFO for found primes.
// Head value and flags come straight from registered state.
module prime_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // a pop frees the slot, so a push may land in the same cycle when full
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/prime_range_scanner.sv
// Sweeps lo..hi by trial division and streams primes out of a FIFO.
// Optional macro PRIME_SKIP_EVEN_EN: reject evens fast, odd divisors only.
module prime_range_scanner
    import prime_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] prime_out,
    output logic         prime_valid,
    input  logic         prime_ready,
    output logic [W-1:0] prime_count
);

`ifdef PRIME_SKIP_EVEN_EN
    localparam logic [W-1:0] D0     = W'(3);
    localparam logic [W-1:0] D_STEP = W'(2);
`else
    localparam logic [W-1:0] D0     = W'(2);
    localparam logic [W-1:0] D_STEP = W'(1);
`endif

    state_t         state;
    state_t         nxt;
    logic [W-1:0]   lo_r;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   n;
    logic [W-1:0]   d;
    logic [W-1:0]   cnt;
    logic [2*W-1:0] dd;
    logic [2*W-1:0] nw;
    logic           rem_zero;
    logic           even_rej;
    logic           is_prime;
    logic           is_comp;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           push_ok;

    assign dd       = {{W{1'b0}}, d} * {{W{1'b0}}, d};
    assign nw       = {{W{1'b0}}, n};
    assign rem_zero = ((n % d) == '0);
`ifdef PRIME_SKIP_EVEN_EN
    assign even_rej = !n[0] && (n != W'(2));
`else
    assign even_rej = 1'b0;
`endif

    assign pop     = !empty && prime_ready;
    assign push    = (state == PUSH);
    assign push_ok = !full || pop;

    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);
    assign prime_valid = !empty;
    assign prime_count = cnt;

    // one trial-division step on the current candidate
    always_comb begin
        is_prime = 1'b0;
        is_comp  = 1'b0;
        if (n < W'(2))      is_comp  = 1'b1;
        else if (even_rej)  is_comp  = 1'b1;
        else if (dd > nw)   is_prime = 1'b1;
        else if (rem_zero)  is_comp  = 1'b1;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (start) nxt = LOAD;
            LOAD:  nxt = (lo_r > hi_r) ? DRAIN : TEST;
            TEST: begin
                if (is_prime)     nxt = PUSH;
                else if (is_comp) nxt = NEXT;
            end
            PUSH:  if (push_ok) nxt = NEXT;
            NEXT:  nxt = (n == hi_r) ? DRAIN : TEST;
            DRAIN: if (empty) nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // candidate, divisor, range and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= '0;
            hi_r <= '0;
            n    <= '0;
            d    <= '0;
            cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    lo_r <= lo;
                    hi_r <= hi;
                    cnt  <= '0;
                end
                LOAD: begin
                    n <= lo_r;
                    d <= D0;
                end
                TEST: if (!is_prime && !is_comp) d <= d + D_STEP;
                PUSH: if (push_ok && cnt != {W{1'b1}}) cnt <= cnt + 1'b1;
                NEXT: if (n != hi_r) begin
                    n <= n + 1'b1;
                    d <= D0;
                end
                default: ;
            endcase
        end
    end

    prime_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (n),
        .pop   (pop),
        .dout  (prime_out),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_prime_range_scanner.sv
// Directed bench for prime_range_scanner.
// Table of ranges plus stall, reset and busy-start sequences.
module tb_prime_range_scanner;

    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] lo = '0;
    logic [7:0] hi = '0;
    logic       busy;
    logic       done;
    logic [7:0] prime_out;
    logic       prime_valid;
    logic       prime_ready = 1'b1;
    logic [7:0] prime_count;

    int total = 0;
    int bad   = 0;
    int spur_at = -1;
    int got[$];

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         cnt;
        int         first;
        int         last;
        int         spur;
    } vec_t;

    vec_t tv[9];

    prime_range_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .busy        (busy),
        .done        (done),
        .prime_out   (prime_out),
        .prime_valid (prime_valid),
        .prime_ready (prime_ready),
        .prime_count (prime_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic bit is_p(input int v);
        if (v < 2) return 1'b0;
        for (int i = 2; i < v; i++)
            if (v % i == 0) return 1'b0;
        return 1'b1;
    endfunction

    // run until done, recording every accepted prime
    task automatic collect(output int cyc, output int ndone);
        cyc = 0;
        ndone = 0;
        while (ndone == 0 && cyc < BUDGET) begin
            if (prime_valid && prime_ready) got.push_back(int'(prime_out));
            if (done) ndone++;
            if (cyc == spur_at) begin
                start = 1'b1;
                lo = 8'd100;
                hi = 8'd200;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= BUDGET) chk("timeout", cyc, 0);
    endtask

    task automatic kick(input logic [7:0] l, input logic [7:0] h);
        got.delete();
        @(negedge clk);
        lo = l;
        hi = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic seq_chk(input string name, input int l, input int h);
        int exp[$];
        int errs;
        errs = 0;
        for (int v = l; v <= h; v++)
            if (is_p(v)) exp.push_back(v);
        if (exp.size() != got.size()) errs++;
        else
            for (int i = 0; i < exp.size(); i++)
                if (exp[i] != got[i]) errs++;
        chk(name, errs, 0);
    endtask

    initial begin
        int cyc;
        int nd;
        int unstable;

        tv[0] = '{8'd0,   8'd30,  10, 2,   29,  -1};
        tv[1] = '{8'd20,  8'd10,  0,  0,   0,   -1};
        tv[2] = '{8'd250, 8'd255, 1,  251, 251, -1};
        tv[3] = '{8'd0,   8'd10,  4,  2,   7,   -1};
        tv[4] = '{8'd0,   8'd1,   0,  0,   0,   -1};
        tv[5] = '{8'd2,   8'd2,   1,  2,   2,   -1};
        tv[6] = '{8'd13,  8'd13,  1,  13,  13,  -1};
        tv[7] = '{8'd14,  8'd16,  0,  0,   0,   -1};
        tv[8] = '{8'd0,   8'd30,  10, 2,   29,  10};

        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst valid", int'(prime_valid), 0);
        chk("rst out", int'(prime_out), 0);
        chk("rst count", int'(prime_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            prime_ready = 1'b1;
            spur_at = tv[k].spur;
            kick(tv[k].lo, tv[k].hi);
            chk($sformatf("v%0d busy", k), int'(busy), 1);
            collect(cyc, nd);
            spur_at = -1;
            chk($sformatf("v%0d ndone", k), nd, 1);
            chk($sformatf("v%0d pulse", k), int'(done), 0);
            chk($sformatf("v%0d idle", k), int'(busy), 0);
            chk($sformatf("v%0d n", k), got.size(), tv[k].cnt);
            chk($sformatf("v%0d count", k), int'(prime_count), tv[k].cnt);
            if (tv[k].cnt > 0) begin
                chk($sformatf("v%0d first", k), got[0], tv[k].first);
                chk($sformatf("v%0d last", k), got[got.size()-1], tv[k].last);
            end
            seq_chk($sformatf("v%0d seq", k), int'(tv[k].lo), int'(tv[k].hi));
            if (tv[k].lo > tv[k].hi)
                chk($sformatf("v%0d fast", k), int'(cyc <= 5), 1);
        end

        // backpressure: FIFO fills, head stays at 2, FSM stalls
        prime_ready = 1'b0;
        kick(8'd2, 8'd40);
        repeat (6) @(negedge clk);
        chk("bp valid", int'(prime_valid), 1);
        chk("bp head", int'(prime_out), 2);
        unstable = 0;
        for (int i = 0; i < 80; i++) begin
            if (!prime_valid || prime_out != 8'd2 || done) unstable++;
            @(negedge clk);
        end
        chk("bp stable", unstable, 0);
        chk("bp count", int'(prime_count), 4);
        chk("bp busy", int'(busy), 1);
        prime_ready = 1'b1;
        collect(cyc, nd);
        chk("bp ndone", nd, 1);
        chk("bp n", got.size(), 12);
        chk("bp count2", int'(prime_count), 12);
        seq_chk("bp seq", 2, 40);

        // reset mid sweep, then a fresh short sweep
        kick(8'd0, 8'd255);
        repeat (100) @(negedge clk);
        chk("mid busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar busy", int'(busy), 0);
        chk("ar valid", int'(prime_valid), 0);
        chk("ar out", int'(prime_out), 0);
        chk("ar count", int'(prime_count), 0);
        chk("ar done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        kick(8'd0, 8'd10);
        collect(cyc, nd);
        chk("ar ndone", nd, 1);
        chk("ar count2", int'(prime_count), 4);
        seq_chk("ar seq", 0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
